// File: rtl/ship_fire_ctrl.sv
// ship_fire_ctrl: turns the fire key into one-frame activation pulses for the
// ship projectile slots. It enforces a refire cooldown, hands shots out
// round-robin across free slots, and counts the shots issued.
// One frame_clk cycle is one video frame.
//
// Ports:
//   frame_clk   - frame clock; all state changes on its rising edge
//   Reset       - asynchronous, active-low reset
//   keycode     - current keyboard keycode
//   ShipAlive   - 1 = ship may fire
//   ProjBusy    - per-slot ProjEn fed back from each projectile instance
//   ProjActvt   - one-hot activation pulse, one frame wide
//   FireBlocked - one-frame pulse when a request is dropped because no slot is free
//   ShotsFired  - saturating count of shots issued
//   CoolActive  - high while the refire cooldown runs
module ship_fire_ctrl #(
    parameter int unsigned NUM_SLOTS = 2,
    parameter int unsigned COOLDOWN  = 8,
    parameter logic [7:0]  FIRE_KEY  = 8'h2C,
    parameter bit          AUTOFIRE  = 1'b0
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [7:0]           keycode,
    input  logic                 ShipAlive,
    input  logic [NUM_SLOTS-1:0] ProjBusy,
    output logic [NUM_SLOTS-1:0] ProjActvt,
    output logic                 FireBlocked,
    output logic [15:0]          ShotsFired,
    output logic                 CoolActive
);

    localparam int unsigned SlotW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned CntW  = (COOLDOWN > 2) ? $clog2(COOLDOWN) : 1;
    localparam logic [CntW-1:0]  CoolInit = CntW'(COOLDOWN - 1);
    localparam logic [SlotW-1:0] LastSlot = SlotW'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {StIdle, StFire, StCool} state_e;

    state_e               state_q, state_d;
    logic                 key_prev_q;
    logic [NUM_SLOTS-1:0] reserved_q, reserved_d;
    logic [SlotW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SlotW-1:0]     sel_q, sel_d;
    logic [CntW-1:0]      cool_cnt_q, cool_cnt_d;
    logic [NUM_SLOTS-1:0] proj_actvt_q, proj_actvt_d;
    logic                 fire_blocked_q, fire_blocked_d;
    logic [15:0]          shots_q, shots_d;
    logic                 cool_active_q, cool_active_d;

    logic                 key_hit;
    logic                 req;
    logic [NUM_SLOTS-1:0] free;
    logic                 found;
    logic [SlotW-1:0]     pick;

    assign key_hit = (keycode == FIRE_KEY);
    // Without autofire only the press edge counts, so a held key fires once.
    assign req     = AUTOFIRE ? key_hit : (key_hit & ~key_prev_q);
    assign free    = ~ProjBusy & ~reserved_q;

    // First free slot at or above rr_ptr, wrapping at NUM_SLOTS.
    always_comb begin
        logic [31:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            idx = (32'(rr_ptr_q) + k) % NUM_SLOTS;
            if (!found && free[idx[SlotW-1:0]]) begin
                found = 1'b1;
                pick  = idx[SlotW-1:0];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        // A slot that has raised ProjEn no longer needs its reservation.
        reserved_d     = reserved_q & ~ProjBusy;
        rr_ptr_d       = rr_ptr_q;
        sel_d          = sel_q;
        cool_cnt_d     = cool_cnt_q;
        proj_actvt_d   = '0;
        fire_blocked_d = 1'b0;
        shots_d        = shots_q;
        cool_active_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req && ShipAlive) begin
                    if (found) begin
                        state_d      = StFire;
                        sel_d        = pick;
                        // Registered so the pulse is visible during the FIRE cycle.
                        proj_actvt_d = NUM_SLOTS'(1) << pick;
                    end else begin
                        fire_blocked_d = 1'b1;
                    end
                end
            end
            StFire: begin
                reserved_d[sel_q] = 1'b1;
                rr_ptr_d          = (sel_q == LastSlot) ? '0 : sel_q + SlotW'(1);
                if (shots_q != 16'hFFFF) begin
                    shots_d = shots_q + 16'd1;
                end
                cool_cnt_d    = CoolInit;
                cool_active_d = 1'b1;
                state_d       = StCool;
            end
            StCool: begin
                if (cool_cnt_q == '0) begin
                    state_d    = StIdle;
                    // Covers the Halt->Init frame before ProjEn comes up.
                    reserved_d = '0;
                end else begin
                    cool_cnt_d    = cool_cnt_q - CntW'(1);
                    cool_active_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_q        <= StIdle;
            key_prev_q     <= 1'b0;
            reserved_q     <= '0;
            rr_ptr_q       <= '0;
            sel_q          <= '0;
            cool_cnt_q     <= '0;
            proj_actvt_q   <= '0;
            fire_blocked_q <= 1'b0;
            shots_q        <= '0;
            cool_active_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_prev_q     <= key_hit;
            reserved_q     <= reserved_d;
            rr_ptr_q       <= rr_ptr_d;
            sel_q          <= sel_d;
            cool_cnt_q     <= cool_cnt_d;
            proj_actvt_q   <= proj_actvt_d;
            fire_blocked_q <= fire_blocked_d;
            shots_q        <= shots_d;
            cool_active_q  <= cool_active_d;
        end
    end

    assign ProjActvt   = proj_actvt_q;
    assign FireBlocked = fire_blocked_q;
    assign ShotsFired  = shots_q;
    assign CoolActive  = cool_active_q;

endmodule
